// File: rtl/poly_calc_stream.sv
// Streaming evaluator of q = floor(((a - b)(1 + 3c) - 4d) / 2) with per-operand FWFT FIFOs and a 4-stage pipeline.
// Define POLY_CALC_SAT_EN to saturate out-of-range results; otherwise the result wraps.
module poly_calc_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] c_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    input  logic                  a_valid_i,
    input  logic                  b_valid_i,
    input  logic                  c_valid_i,
    input  logic                  d_valid_i,
    output logic                  a_ready_o,
    output logic                  b_ready_o,
    output logic                  c_ready_o,
    output logic                  d_ready_o,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  q_valid_o,
    input  logic                  q_ready_i,
    output logic                  q_ovf_o
);
    localparam int W  = DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]         FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic signed [W+2:0] M_ONE    = {{(W+2){1'b0}}, 1'b1};
    localparam logic [W-1:0]        Q_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]        Q_MIN    = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] ch_data [4];
    logic [W-1:0] ch_head [4];
    logic [3:0]   ch_valid;
    logic [3:0]   ch_ready;
    logic [3:0]   ch_empty;
    logic         en;
    logic         pop;
    logic         q_valid_q, q_valid_d;

    assign ch_data[0] = a_i;
    assign ch_data[1] = b_i;
    assign ch_data[2] = c_i;
    assign ch_data[3] = d_i;
    assign ch_valid   = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};
    assign {d_ready_o, c_ready_o, b_ready_o, a_ready_o} = ch_ready;

    assign en  = !(q_valid_q && !q_ready_i);
    assign pop = en && (ch_empty == 4'b0000);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo
            logic [W-1:0]  mem [FIFO_DEPTH];
            logic [AW-1:0] wr_ptr_q, wr_ptr_d;
            logic [AW-1:0] rd_ptr_q, rd_ptr_d;
            logic [AW:0]   cnt_q, cnt_d;
            logic          push;

            // Ready is forced low while reset is held so nothing is pushed into a FIFO being cleared.
            assign ch_ready[gi] = !arst_i && (cnt_q != FULL_CNT);
            assign ch_empty[gi] = (cnt_q == '0);
            assign ch_head[gi]  = mem[rd_ptr_q];
            assign push         = ch_valid[gi] && ch_ready[gi];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                cnt_d    = cnt_q;
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   cnt_d = cnt_q + 1'b1;
                    2'b01:   cnt_d = cnt_q - 1'b1;
                    default: cnt_d = cnt_q;
                endcase
            end

            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end

            always_ff @(posedge clk_i) begin
                if (push) mem[wr_ptr_q] <= ch_data[gi];
            end
        end
    endgenerate

    logic signed [W:0]     s1_diff_q, s1_diff_d;
    logic signed [W+2:0]   s1_m_q, s1_m_d;
    logic signed [W+1:0]   s1_d4_q, s1_d4_d;
    logic signed [2*W+3:0] s2_prod_q, s2_prod_d;
    logic signed [W+1:0]   s2_d4_q, s2_d4_d;
    logic signed [2*W+3:0] s3_r_q, s3_r_d;
    logic [W-1:0]          q_q, q_d;
    logic                  ovf_q, ovf_d;
    logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

    logic signed [W+2:0]   c_ext;
    logic signed [2*W+3:0] diff_ext, m_ext;
    logic signed [2*W+4:0] pre_shift;
    logic [W+4:0]          r_hi;
    logic                  r_ovf;

    always_comb begin
        s1_diff_d = s1_diff_q;
        s1_m_d    = s1_m_q;
        s1_d4_d   = s1_d4_q;
        s2_prod_d = s2_prod_q;
        s2_d4_d   = s2_d4_q;
        s3_r_d    = s3_r_q;
        q_d       = q_q;
        ovf_d     = ovf_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        v3_d      = v3_q;
        q_valid_d = q_valid_q;

        c_ext     = {{3{ch_head[2][W-1]}}, ch_head[2]};
        diff_ext  = {{(W+3){s1_diff_q[W]}}, s1_diff_q};
        m_ext     = {{(W+1){s1_m_q[W+2]}}, s1_m_q};
        pre_shift = {s2_prod_q[2*W+3], s2_prod_q} - {{(W+3){s2_d4_q[W+1]}}, s2_d4_q};
        // The result fits W bits only when every bit above W-1 repeats the sign bit.
        r_hi      = s3_r_q[2*W+3:W-1];
        r_ovf     = !((&r_hi) || (~|r_hi));

        if (en) begin
            v1_d      = pop;
            s1_diff_d = {ch_head[0][W-1], ch_head[0]} - {ch_head[1][W-1], ch_head[1]};
            s1_m_d    = c_ext + (c_ext <<< 1) + M_ONE;
            s1_d4_d   = {ch_head[3], 2'b00};

            v2_d      = v1_q;
            s2_prod_d = diff_ext * m_ext;
            s2_d4_d   = s1_d4_q;

            v3_d      = v2_q;
            s3_r_d    = pre_shift[2*W+4:1];

            q_valid_d = v3_q;
            ovf_d     = r_ovf;
`ifdef POLY_CALC_SAT_EN
            q_d       = r_ovf ? (s3_r_q[2*W+3] ? Q_MIN : Q_MAX) : s3_r_q[W-1:0];
`else
            q_d       = s3_r_q[W-1:0];
`endif
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s1_diff_q <= '0;
            s1_m_q    <= '0;
            s1_d4_q   <= '0;
            s2_prod_q <= '0;
            s2_d4_q   <= '0;
            s3_r_q    <= '0;
            q_q       <= '0;
            ovf_q     <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            q_valid_q <= 1'b0;
        end else begin
            s1_diff_q <= s1_diff_d;
            s1_m_q    <= s1_m_d;
            s1_d4_q   <= s1_d4_d;
            s2_prod_q <= s2_prod_d;
            s2_d4_q   <= s2_d4_d;
            s3_r_q    <= s3_r_d;
            q_q       <= q_d;
            ovf_q     <= ovf_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign q_o       = q_q;
    assign q_ovf_o   = ovf_q;
    assign q_valid_o = q_valid_q;
endmodule
